// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS-subset core driving external synchronous RAMs
//
// Purpose:
//   Fetch/decode/execute/mem/writeback FSM for a MIPS subset:
//   ADD (funct 0x20 and legacy 0x10), SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, J and HALT.
//   The instruction and data memories are external. Both have one cycle of read latency.
//
// Ports:
//   CLOCK_50    in   core clock; all state changes on the rising edge
//   KEY0        in   synchronous active-low reset
//   imem_addr   out  instruction word address (the PC)
//   imem_rdata  in   instruction word, valid one cycle after imem_addr
//   dmem_addr   out  data word address
//   dmem_wdata  out  store data
//   dmem_we     out  write strobe, high for one cycle per SW
//   dmem_rdata  in   load data, valid one cycle after dmem_addr
//   dbg_sel     in   register index for debug read
//   dbg_data    out  combinational read of registers[dbg_sel]
//   state       out  current FSM state encoding
//   instr_done  out  one-cycle pulse on the FETCH cycle that follows a retired instruction
//   illegal     out  sticky flag: unknown opcode or funct was executed
//   halted      out  high while in the absorbing HALT state
//
// Configuration:
//   MIPS_R0_ZERO_EN  When defined, r0 reads as 0 and writes to r0 are discarded.
//                    When undefined, r0 is general purpose and resets to RESET_R0.
module mips_multicycle_core #(
  parameter int          DATA_W   = 32,
  parameter int          PC_W     = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned RESET_R0 = 1
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              illegal,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_FETCH_W = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_MEM_W   = 3'd5,
    S_WB      = 3'd6,
    S_HALT    = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_HALT    = 6'h3F;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADD_OLD = 6'h10;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [PC_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic              illegal_q, illegal_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] regs_q [32];
  logic              rf_we, rf_we_eff;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs_val, rt_val, slt_res;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];

`ifdef MIPS_R0_ZERO_EN
  // r0 storage keeps its reset value but is never observed or written.
  assign rs_val    = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_val    = (rt == 5'd0) ? '0 : regs_q[rt];
  assign dbg_data  = (dbg_sel == 5'd0) ? '0 : regs_q[dbg_sel];
  assign rf_we_eff = rf_we && (rf_waddr != 5'd0);
`else
  assign rs_val    = regs_q[rs];
  assign rt_val    = regs_q[rt];
  assign dbg_data  = regs_q[dbg_sel];
  assign rf_we_eff = rf_we;
`endif

  assign slt_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};

  assign imem_addr  = pc_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_we    = (state_q == S_MEM) && (op == OP_SW);
  assign state      = state_q;
  assign instr_done = done_q;
  assign illegal    = illegal_q;
  assign halted     = (state_q == S_HALT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_q;

    case (state_q)
      S_FETCH: state_d = S_FETCH_W;

      S_FETCH_W: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end

      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        imm_d   = DATA_W'($signed(ir_q[15:0]));
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            state_d = S_WB;
            case (funct)
              FN_ADD, FN_ADD_OLD: alu_d = a_q + b_q;
              FN_SUB:             alu_d = a_q - b_q;
              FN_AND:             alu_d = a_q & b_q;
              FN_OR:              alu_d = a_q | b_q;
              FN_SLT:             alu_d = slt_res;
              default: begin
                illegal_d = 1'b1;
                state_d   = S_FETCH;
                done_d    = 1'b1;
              end
            endcase
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_q;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            // Only the low PC_W bits of the effective address reach the RAM.
            daddr_d  = a_q[PC_W-1:0] + imm_q[PC_W-1:0];
            dwdata_d = b_q;
            state_d  = S_MEM;
          end
          OP_BEQ: begin
            // PC already points past the branch, so the offset is relative to PC+1.
            if (a_q == b_q) pc_d = pc_q + imm_q[PC_W-1:0];
            state_d = S_FETCH;
            done_d  = 1'b1;
          end
          OP_J: begin
            pc_d    = ir_q[PC_W-1:0];
            state_d = S_FETCH;
            done_d  = 1'b1;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
            done_d    = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        if (op == OP_SW) begin
          state_d = S_FETCH;
          done_d  = 1'b1;
        end else begin
          state_d = S_MEM_W;
        end
      end

      S_MEM_W: begin
        mdr_d   = dmem_rdata;
        state_d = S_WB;
      end

      S_WB: begin
        rf_we = 1'b1;
        if (op == OP_RTYPE) begin
          rf_waddr = rd;
          rf_wdata = alu_q;
        end else if (op == OP_LW) begin
          rf_waddr = rt;
          rf_wdata = mdr_q;
        end else begin
          rf_waddr = rt;
          rf_wdata = alu_q;
        end
        state_d = S_FETCH;
        done_d  = 1'b1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 0) ? DATA_W'(RESET_R0) : '0;
      end
    end else if (rf_we_eff) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench for mips_multicycle_core
module tb_mips_multicycle_core;

`ifdef MIPS_R0_ZERO_EN
  localparam logic [31:0] R0       = 32'd0;
  localparam logic [31:0] R0_AFTER = 32'd0;
`else
  localparam logic [31:0] R0       = 32'd1;
  localparam logic [31:0] R0_AFTER = 32'd6;
`endif
  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        KEY0;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_data;
  logic        dmem_we, instr_done, illegal, halted;
  logic [4:0]  dbg_sel;
  logic [2:0]  state;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;

  typedef struct {
    int          lat;
    logic [9:0]  pc;
    logic [4:0]  idx;
    logic [31:0] val;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;
  exp_t sb[$];
  wr_t  wq[$];

  mips_multicycle_core dut (
    .CLOCK_50  (clk),
    .KEY0      (KEY0),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we   (dmem_we),
    .dmem_rdata(dmem_rdata),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .state     (state),
    .instr_done(instr_done),
    .illegal   (illegal),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(posedge clk) begin
    if (!KEY0) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int lat, input logic [9:0] pc, input logic [4:0] idx,
                      input logic [31:0] val, input logic ill);
    exp_t e;
    e.lat = lat; e.pc = pc; e.idx = idx; e.val = val; e.ill = ill;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_state"},   {29'd0, state}, 32'd0);
    chk({tag, "_pc"},      {22'd0, imem_addr}, 32'd0);
    chk({tag, "_done"},    {31'd0, instr_done}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, "_halted"},  {31'd0, halted}, 32'd0);
    chk({tag, "_we"},      {31'd0, dmem_we}, 32'd0);
    chk({tag, "_daddr"},   {22'd0, dmem_addr}, 32'd0);
    chk({tag, "_wdata"},   dmem_wdata, 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d retire and %0d store expectations still pending after %0d cycles",
               tag, sb.size(), wq.size(), maxc);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int maxc);
    int n = 0;
    while (state !== st && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, st});
  endtask

  // Monitor: every retire pulse and every store strobe is matched against the queues.
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!KEY0) begin
        last_cyc = 0;
      end else begin
        if (dmem_we) begin
          if (wq.size() == 0) begin
            chk("unexpected_store", 32'd1, 32'd0);
          end else begin
            w = wq.pop_front();
            chk("store_addr", {22'd0, dmem_addr}, {22'd0, w.addr});
            chk("store_data", dmem_wdata, w.data);
          end
        end
        if (instr_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - last_cyc, e.lat);
            last_cyc = cyc;
            chk("pc", {22'd0, imem_addr}, {22'd0, e.pc});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            dbg_sel = e.idx;
            #1;
            chk($sformatf("r%0d", e.idx), dbg_data, e.val);
          end
        end
      end
    end
  end

  initial begin
    KEY0    = 1'b0;
    dbg_sel = 5'd0;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = HALT_I;
      dmem[i] = 32'd0;
    end

    // Program 1: ALU ops, store/load, branches both ways, illegal funct, jump and PC wrap.
    imem[0]     = 32'h0020_1820;                         // ADD  r3,r1,r0
    imem[1]     = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);    // ADDI r1,r1,-1
    imem[2]     = enc_r(5'd1, 5'd0, 5'd2, 6'h2A);        // SLT  r2,r1,r0
    imem[3]     = enc_r(5'd0, 5'd1, 5'd4, 6'h22);        // SUB  r4,r0,r1
    imem[4]     = enc_i(6'h08, 5'd2, 5'd7, 16'h00F0);    // ADDI r7,r2,0xF0
    imem[5]     = enc_r(5'd7, 5'd4, 5'd8, 6'h25);        // OR   r8,r7,r4
    imem[6]     = enc_r(5'd8, 5'd3, 5'd6, 6'h24);        // AND  r6,r8,r3
    imem[7]     = enc_i(6'h2B, 5'd0, 5'd1, 16'h0004);    // SW   r1,4(r0)
    imem[8]     = enc_i(6'h23, 5'd0, 5'd5, 16'h0004);    // LW   r5,4(r0)
    imem[9]     = enc_r(5'd1, 5'd4, 5'd9, 6'h2A);        // SLT  r9,r1,r4
    imem[10]    = enc_r(5'd5, 5'd7, 5'd10, 6'h10);       // ADD  r10,r5,r7 (legacy funct)
    imem[11]    = enc_i(6'h04, 5'd9, 5'd7, 16'h0005);    // BEQ  r9,r7,+5 (not taken)
    imem[12]    = enc_i(6'h04, 5'd3, 5'd3, 16'h0002);    // BEQ  r3,r3,+2 (taken)
    imem[13]    = enc_i(6'h08, 5'd0, 5'd11, 16'h0055);   // skipped
    imem[14]    = enc_i(6'h08, 5'd0, 5'd11, 16'h0055);   // skipped
    imem[15]    = enc_r(5'd1, 5'd1, 5'd12, 6'h3F);       // illegal funct
    imem[16]    = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);    // BEQ  r0,r0,+2
    imem[17]    = {6'h02, 26'h3FF};                      // J    0x3FF
    imem[18]    = enc_i(6'h08, 5'd0, 5'd11, 16'h0055);   // skipped
    imem[19]    = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFD);    // BEQ  r0,r0,-3
    imem[10'h3FF] = enc_i(6'h08, 5'd0, 5'd0, 16'h0005);  // ADDI r0,r0,5

    push(5, 10'd1,  5'd3,  R0, 1'b0);
    push(5, 10'd2,  5'd1,  32'hFFFF_FFFF, 1'b0);
    push(5, 10'd3,  5'd2,  32'd1, 1'b0);
    push(5, 10'd4,  5'd4,  R0 + 32'd1, 1'b0);
    push(5, 10'd5,  5'd7,  32'h0000_00F1, 1'b0);
    push(5, 10'd6,  5'd8,  32'h0000_00F1 | (R0 + 32'd1), 1'b0);
    push(5, 10'd7,  5'd6,  (32'h0000_00F1 | (R0 + 32'd1)) & R0, 1'b0);
    push(5, 10'd8,  5'd1,  32'hFFFF_FFFF, 1'b0);
    push(7, 10'd9,  5'd5,  32'hFFFF_FFFF, 1'b0);
    push(5, 10'd10, 5'd9,  32'd1, 1'b0);
    push(5, 10'd11, 5'd10, 32'h0000_00F0, 1'b0);
    push(4, 10'd12, 5'd10, 32'h0000_00F0, 1'b0);
    push(4, 10'd15, 5'd11, 32'd0, 1'b0);
    push(4, 10'd16, 5'd12, 32'd0, 1'b1);
    push(4, 10'd19, 5'd11, 32'd0, 1'b1);
    push(4, 10'd17, 5'd11, 32'd0, 1'b1);
    push(4, 10'h3FF, 5'd11, 32'd0, 1'b1);
    push(5, 10'd0,  5'd0,  R0_AFTER, 1'b1);
    begin
      wr_t w;
      w.addr = R0[9:0] + 10'd4;
      w.data = 32'hFFFF_FFFF;
      wq.push_back(w);
    end

    repeat (3) @(negedge clk);
    check_reset("rst0");
    KEY0 = 1'b1;
    wait_idle("prog1_idle", 1000);

    // Program 2: reset in the middle of a load, then HALT.
    KEY0    = 1'b0;
    imem[0] = enc_i(6'h08, 5'd1, 5'd1, 16'h0003);        // ADDI r1,r1,3
    imem[1] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);        // LW   r2,0(r1)
    @(negedge clk);
    @(negedge clk);
    check_reset("rst1");
    push(5, 10'd1, 5'd1, 32'd3, 1'b0);
    KEY0 = 1'b1;
    wait_state("reach_mem_w", 3'd5, 50);
    chk("lw_addr", {22'd0, dmem_addr}, 32'd3);
    KEY0    = 1'b0;
    imem[1] = HALT_I;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst_mid_lw");
    push(5, 10'd1, 5'd1, 32'd3, 1'b0);
    KEY0 = 1'b1;
    wait_state("reach_halt", 3'd7, 50);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {22'd0, imem_addr}, 32'd2);
    repeat (20) @(negedge clk);
    chk("halt_hold_state", {29'd0, state}, 32'd7);
    chk("halt_hold_pc", {22'd0, imem_addr}, 32'd2);
    chk("halt_hold_flag", {31'd0, halted}, 32'd1);
    wait_idle("prog2_idle", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
